fetch_mem_arbiter: RTL and testbench
====================================

# fetch_mem_arbiter

Sequences a single-ported unified instruction/data memory between the instruction-fetch stage and the data-memory stage of the MIPS pipeline. Each requester gets one outstanding transaction at a time. Data accesses have priority, bounded by a starvation limit. A watchdog aborts memory transactions that are never acknowledged. The block also drives the PC enable and the pipeline stall, so the fetch stage advances only when an instruction word has actually been returned.

## Interface
Parameters:
- MAX_DATA_STREAK, 4: consecutive data grants allowed while a fetch is pending; range 1..15.
- TIMEOUT, 31: memory-wait cycles before abort; range 1..255.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  reset; synchronous, active-high.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch address (PC).
- halted  in  1  processor halted; suppresses new fetch grants.
- if_ready  out  1  one-cycle fetch completion pulse.
- if_inst  out  32  fetched word, registered.
- dm_req  in  1  data request.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_ready  out  1  one-cycle data completion pulse.
- dm_rdata  out  32  load data, registered.
- mem_en  out  1  memory transaction active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion, sampled while mem_en=1.
- mem_err  out  1  one-cycle pulse when a transaction times out.
- pc_enable  out  1  PC may advance this cycle.
- stall  out  1  freeze the pipeline registers this cycle.

## Operation
States:
- IDLE: arbitrates among valid requests.
- BUSY_I: memory fetch in progress.
- BUSY_D: memory data access in progress.
- RESP: response cycle.

Arbitration in IDLE:
- A valid fetch request is if_req=1 and halted=0.
- Data request only: grant data.
- Fetch request only: grant fetch.
- Both requests: grant data, unless streak_cnt equals MAX_DATA_STREAK; then grant fetch.
- Neither request: stay in IDLE.

Streak counter (streak_cnt, 4 bits):
- Increments on a data grant while a valid fetch request is pending.
- Clears on a fetch grant, or on a data grant with no fetch pending.
- Saturates at MAX_DATA_STREAK.

Grant:
- The granted address, we and wdata are latched at the grant edge. mem_we=0 for fetches.
- mem_en, mem_we, mem_addr and mem_wdata stay stable for the whole BUSY state.

Completion in BUSY_x:
- mem_ack=1: capture mem_rdata into if_inst (fetch) or dm_rdata (load); go to RESP.
- Store completion leaves dm_rdata unchanged.
- Watchdog: a counter clears on entry to BUSY_x and increments every BUSY cycle without mem_ack.
- Counter reaches TIMEOUT: abort. Go to RESP with the captured data forced to 0 and mem_err=1 during RESP.

RESP:
- The matching ready output is 1.
- No new grant is made; the next state is IDLE.
- A requester must drop or change its request at the edge that ends RESP. A request seen in the following IDLE cycle is treated as a new transaction.

Halt and reset:
- halted=1 only blocks new fetch grants. A fetch already in BUSY_I completes normally.
- Reset mid-transaction abandons the transaction with no ready pulse. mem_en drops at the reset edge.

Combinational outputs:
- pc_enable = if_ready & ~halted.
- stall = (if_req & ~halted & ~if_ready) | (dm_req & ~dm_ready).

Reset values:
- State IDLE.
- Every output is 0, including if_inst, dm_rdata, mem_addr and mem_wdata.
- streak_cnt and the watchdog counter are 0.

## Timing
- Request in IDLE at cycle t → mem_en=1 from t+1.
- mem_ack at cycle k → ready=1 and data valid at k+1 → IDLE at k+2.
- Minimum latency with ack in the first BUSY cycle: ready 2 cycles after the request. Throughput is one transaction per 3 cycles.
- mem_ack outside a BUSY state is ignored.
- A timed-out transaction pulses ready and mem_err together, TIMEOUT+1 cycles after entering BUSY.
- Requests arriving in BUSY or RESP wait; they are not dropped.

## Test plan
- Fetch only, zero-wait memory: if_req=1, if_addr=0x40, ack in the first BUSY cycle, mem_rdata=0x8C220004 → if_ready and pc_enable at cycle 2; if_inst=0x8C220004; stall=1 in cycles 0–1.
- Simultaneous requests: if_req=1 and dm_req=1 (load 0x100) → data is granted first. dm_ready arrives before if_ready, and the fetch is granted in the IDLE cycle after the data RESP.
- Starvation: dm_req held high continuously with a new address each transaction, if_req=1, MAX_DATA_STREAK=4 → four data completions, then a fetch grant, then data again.
- Timeout: load with no mem_ack and TIMEOUT=31 → dm_ready=1, mem_err=1 and dm_rdata=0 in cycle 33; mem_en drops in that same cycle.
- Halt: halted=1 with if_req=1 → no grant ever, mem_en=0, pc_enable=0. With halted raised during BUSY_I, the fetch completes and if_ready=1, but pc_enable stays 0.
- Reset during BUSY_D (store to 0x200) → the next cycle has mem_en=0, all outputs 0 and no dm_ready pulse; a fresh request is granted normally afterwards.

Source files
------------

// File: rtl/fetch_mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Data has priority up to a starvation limit; a watchdog aborts unacknowledged transactions.
module fetch_mem_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        halted,
    output logic        if_ready,
    output logic [31:0] if_inst,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_err,
    output logic        pc_enable,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_r;
    logic [3:0]  streak_r;
    logic [7:0]  wdog_r;
    logic        if_valid_s;
    logic        streak_full_s;
    logic        grant_d_s;
    logic        grant_i_s;
    logic        wdog_expired_s;

    // Arbitration decision and watchdog expiry
    always_comb begin
        if_valid_s     = if_req & ~halted;
        streak_full_s  = (streak_r == 4'(MAX_DATA_STREAK));
        grant_d_s      = dm_req & ~(if_valid_s & streak_full_s);
        grant_i_s      = if_valid_s & ~grant_d_s;
        wdog_expired_s = (wdog_r == 8'(TIMEOUT));
    end

    // Pipeline handshake derived from the registered completion pulses
    always_comb begin
        pc_enable = if_ready & ~halted;
        stall     = (if_req & ~halted & ~if_ready) | (dm_req & ~dm_ready);
    end

    // Transaction sequencer with registered memory and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            streak_r  <= 4'd0;
            wdog_r    <= 8'd0;
            if_ready  <= 1'b0;
            if_inst   <= 32'd0;
            dm_ready  <= 1'b0;
            dm_rdata  <= 32'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_err   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        state_r   <= BUSY_D;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        wdog_r    <= 8'd0;
                        // Only data grants that overtake a waiting fetch count toward the streak
                        if (if_valid_s) begin
                            streak_r <= streak_full_s ? streak_r : streak_r + 4'd1;
                        end else begin
                            streak_r <= 4'd0;
                        end
                    end else if (grant_i_s) begin
                        state_r   <= BUSY_I;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= 32'd0;
                        wdog_r    <= 8'd0;
                        streak_r  <= 4'd0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ack || wdog_expired_s) begin
                        state_r <= RESP;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_err <= ~mem_ack;
                        if (state_r == BUSY_I) begin
                            if_ready <= 1'b1;
                            if_inst  <= mem_ack ? mem_rdata : 32'd0;
                        end else begin
                            dm_ready <= 1'b1;
                            if (!mem_we) begin
                                dm_rdata <= mem_ack ? mem_rdata : 32'd0;
                            end
                        end
                    end else begin
                        wdog_r <= wdog_r + 8'd1;
                    end
                end
                RESP: begin
                    if_ready <= 1'b0;
                    dm_ready <= 1'b0;
                    mem_err  <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: directed scenarios, then randomized traffic against
// a transaction-level memory model with a queue-based scoreboard.
module tb_fetch_mem_arbiter;

    localparam int MAX   = 4;
    localparam int TO    = 31;
    localparam int N_TXN = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        halted = 1'b0;
    logic        if_ready;
    logic [31:0] if_inst;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = 32'd0;
    logic [31:0] dm_wdata = 32'd0;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic        mem_err;
    logic        pc_enable;
    logic        stall;

    fetch_mem_arbiter #(.MAX_DATA_STREAK(MAX), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .halted(halted),
        .if_ready(if_ready), .if_inst(if_inst),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
        .pc_enable(pc_enable), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t q_i[$];
    exp_t q_d[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] env_mem[logic [31:0]];
    logic [31:0] last_dm;
    logic done_i = 1'b0;
    logic done_d = 1'b0;
    logic stop = 1'b0;

    // Memory contents before any store, and the per-address response behaviour
    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return a ^ 32'h8C22_0044;
    endfunction

    function automatic logic never_acks(input logic [31:0] a);
        return a[11:8] == 4'hF;
    endfunction

    function automatic int wait_of(input logic [31:0] a);
        return int'(a[3:2]);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rdy(input int budget, output logic got);
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            samp();
            got = if_ready | dm_ready;
        end
    endtask

    // Memory environment: acks after an address-dependent wait, junk ack/data when idle
    initial begin
        logic in_txn;
        int   wcnt;
        in_txn = 1'b0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    wcnt = 0;
                end
                if (!never_acks(mem_addr) && wcnt == wait_of(mem_addr)) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        env_mem[mem_addr] = mem_wdata;
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : mem_init(mem_addr);
                    end
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                end
                wcnt++;
            end else begin
                in_txn = 1'b0;
                mem_ack = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    task automatic run_i();
        logic [31:0] a;
        exp_t e;
        logic got;
        for (int n = 0; n < N_TXN; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            a = {20'd0, 10'($urandom), 2'b00};
            e.err = never_acks(a);
            e.data = e.err ? 32'd0 : ref_read(a);
            q_i.push_back(e);
            if_addr = a;
            if_req = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 400 && !got; k++) begin
                samp();
                got = if_ready;
            end
            chk("if_req_served", 32'(got), 32'd1);
            if_req = 1'b0;
        end
        done_i = 1'b1;
    endtask

    task automatic run_d();
        logic [31:0] a;
        exp_t e;
        logic got;
        logic we;
        logic [31:0] wd;
        for (int n = 0; n < N_TXN; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            a = {19'd0, 1'b1, 10'($urandom), 2'b00};
            we = 1'($urandom);
            wd = $urandom;
            e.err = never_acks(a);
            if (we) begin
                if (!e.err) ref_mem[a] = wd;
                e.data = last_dm;
            end else begin
                e.data = e.err ? 32'd0 : ref_read(a);
                last_dm = e.data;
            end
            q_d.push_back(e);
            dm_addr = a;
            dm_we = we;
            dm_wdata = wd;
            dm_req = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 400 && !got; k++) begin
                samp();
                got = dm_ready;
            end
            chk("dm_req_served", 32'(got), 32'd1);
            dm_req = 1'b0;
        end
        done_d = 1'b1;
    endtask

    task automatic run_halt();
        while (!stop && !done_i) begin
            tick();
            halted = ($urandom_range(0, 5) == 0);
        end
        halted = 1'b0;
    endtask

    // Scoreboard monitor: response data and arbitration rules from observed grants
    task automatic monitor();
        logic prev_en;
        logic prev_ifv;
        logic prev_dm;
        logic kind_d;
        int   streak_m;
        exp_t e;
        prev_en = 1'b0;
        prev_ifv = 1'b0;
        prev_dm = 1'b0;
        streak_m = 0;
        while (!stop) begin
            samp();
            if (if_ready | dm_ready) begin
                chk("one_ready", 32'(if_ready & dm_ready), 32'd0);
                chk("pc_enable", 32'(pc_enable), 32'(if_ready & ~halted));
            end
            if (if_ready) begin
                chk("if_expected", 32'(q_i.size() != 0), 32'd1);
                if (q_i.size() != 0) begin
                    e = q_i.pop_front();
                    chk("if_inst", if_inst, e.data);
                    chk("if_err", 32'(mem_err), 32'(e.err));
                end
            end
            if (dm_ready) begin
                chk("dm_expected", 32'(q_d.size() != 0), 32'd1);
                if (q_d.size() != 0) begin
                    e = q_d.pop_front();
                    chk("dm_rdata", dm_rdata, e.data);
                    chk("dm_err", 32'(mem_err), 32'(e.err));
                end
            end
            if (mem_en && !prev_en) begin
                kind_d = mem_addr[12];
                chk("grant_had_req", 32'(prev_dm | prev_ifv), 32'd1);
                chk("fetch_we0", 32'(mem_we & ~kind_d), 32'd0);
                if (prev_dm && prev_ifv) begin
                    if (kind_d) begin
                        chk("data_under_limit", 32'(streak_m < MAX), 32'd1);
                        if (streak_m < MAX) streak_m++;
                    end else begin
                        chk("fetch_after_streak", 32'(streak_m), 32'(MAX));
                        streak_m = 0;
                    end
                end else begin
                    chk("grant_kind", 32'(kind_d), 32'(prev_dm));
                    streak_m = 0;
                end
            end
            prev_en = mem_en;
            prev_ifv = if_req & ~halted;
            prev_dm = dm_req;
        end
    endtask

    initial begin
        logic got;
        logic [5:0] seq;
        logic bad;

        // Reset state
        repeat (3) samp();
        chk("rst_ctrl", 32'({if_ready, dm_ready, mem_en, mem_we, mem_err, pc_enable, stall}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        reset = 1'b0;

        // Fetch only, zero-wait
        tick();
        if_addr = 32'h40;
        if_req = 1'b1;
        #1;
        chk("f0_stall", 32'(stall), 32'd1);
        chk("f0_mem_en", 32'(mem_en), 32'd0);
        samp();
        chk("f1_mem_en", 32'(mem_en), 32'd1);
        chk("f1_mem_addr", mem_addr, 32'h40);
        chk("f1_stall", 32'(stall), 32'd1);
        samp();
        chk("f2_if_ready", 32'(if_ready), 32'd1);
        chk("f2_pc_enable", 32'(pc_enable), 32'd1);
        chk("f2_if_inst", if_inst, 32'h8C22_0004);
        chk("f2_stall", 32'(stall), 32'd0);
        if_req = 1'b0;

        // Simultaneous requests: data first, fetch right after
        tick();
        if_addr = 32'h44;
        if_req = 1'b1;
        dm_addr = 32'h100;
        dm_we = 1'b0;
        dm_req = 1'b1;
        wait_rdy(50, got);
        chk("sim_first_got", 32'(got), 32'd1);
        chk("sim_first_dm", 32'({dm_ready, if_ready}), 32'd2);
        chk("sim_dm_rdata", dm_rdata, mem_init(32'h100));
        dm_req = 1'b0;
        samp();
        chk("sim_idle", 32'(mem_en), 32'd0);
        samp();
        chk("sim_fetch_grant", 32'({mem_en, mem_we}), 32'd2);
        chk("sim_fetch_addr", mem_addr, 32'h44);
        wait_rdy(50, got);
        chk("sim_if_ready", 32'(if_ready & got), 32'd1);
        chk("sim_if_inst", if_inst, mem_init(32'h44));
        if_req = 1'b0;

        // Starvation limit with data held high
        tick();
        seq = 6'd0;
        if_addr = 32'h48;
        if_req = 1'b1;
        dm_addr = 32'h300;
        dm_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_rdy(100, got);
            chk("starve_got", 32'(got), 32'd1);
            seq[k] = dm_ready;
            if (dm_ready) begin
                chk("starve_dm_rdata", dm_rdata, mem_init(dm_addr));
                dm_addr = dm_addr + 32'd4;
            end
            if (if_ready) if_addr = if_addr + 32'd4;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        chk("starve_order", 32'(seq), 32'h2F);

        // Halted blocks fetch grants; halting during BUSY_I still completes
        tick();
        halted = 1'b1;
        if_addr = 32'h4C;
        if_req = 1'b1;
        bad = 1'b0;
        repeat (8) begin
            samp();
            bad = bad | mem_en | pc_enable | stall;
        end
        chk("halt_no_grant", 32'(bad), 32'd0);
        halted = 1'b0;
        samp();
        chk("halt_release_grant", 32'(mem_en), 32'd1);
        halted = 1'b1;
        wait_rdy(20, got);
        chk("halt_busy_done", 32'(if_ready & got), 32'd1);
        chk("halt_pc_enable", 32'(pc_enable), 32'd0);
        chk("halt_if_inst", if_inst, mem_init(32'h4C));
        if_req = 1'b0;
        halted = 1'b0;

        // Reset during a store
        tick();
        dm_addr = 32'h200;
        dm_we = 1'b1;
        dm_wdata = 32'hDEAD_BEEF;
        dm_req = 1'b1;
        samp();
        chk("rs_busy", 32'({mem_en, mem_we}), 32'd3);
        reset = 1'b1;
        samp();
        chk("rs_ctrl", 32'({if_ready, dm_ready, mem_en, mem_we, mem_err, pc_enable}), 32'd0);
        chk("rs_mem_addr", mem_addr, 32'd0);
        chk("rs_mem_wdata", mem_wdata, 32'd0);
        chk("rs_if_inst", if_inst, 32'd0);
        chk("rs_dm_rdata", dm_rdata, 32'd0);
        reset = 1'b0;
        dm_req = 1'b0;
        dm_we = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            samp();
            bad = bad | dm_ready | mem_en;
        end
        chk("rs_no_ready", 32'(bad), 32'd0);
        tick();
        dm_addr = 32'h104;
        dm_req = 1'b1;
        wait_rdy(20, got);
        chk("rs_fresh_ready", 32'(dm_ready & got), 32'd1);
        chk("rs_fresh_data", dm_rdata, mem_init(32'h104));
        dm_req = 1'b0;

        // Watchdog timeout on a load
        tick();
        dm_addr = 32'hF00;
        dm_req = 1'b1;
        repeat (32) samp();
        chk("to_c32", 32'({mem_en, dm_ready}), 32'd2);
        samp();
        chk("to_c33_ready_err", 32'({dm_ready, mem_err}), 32'd3);
        chk("to_c33_rdata", dm_rdata, 32'd0);
        chk("to_c33_mem_en", 32'(mem_en), 32'd0);
        dm_req = 1'b0;

        // Randomized traffic
        last_dm = 32'd0;
        fork
            run_i();
            run_d();
            run_halt();
            monitor();
        join_none
        for (int c = 0; c < 30000 && !(done_i && done_d); c++) @(posedge clk);
        chk("random_done", 32'(done_i && done_d), 32'd1);
        repeat (5) @(posedge clk);
        stop = 1'b1;
        repeat (2) @(posedge clk);
        chk("q_i_drained", 32'(q_i.size()), 32'd0);
        chk("q_d_drained", 32'(q_d.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
